// File: rtl/pe_pkg.sv
// Shared PE datapath constants and drain-state encoding used by the PE array,
// its operand feeder and the result collector.
package pe_pkg;
    localparam int DP_DEF         = 256;
    localparam int DATA_WIDTH_DEF = 54;
    localparam int BEAT_LANES_DEF = 16;
    localparam int PE_LATENCY_DEF = 4;
    localparam int ADDR_WIDTH_DEF = 16;

    localparam int LANE_W     = DATA_WIDTH_DEF;
    localparam int NUM_BEATS  = DP_DEF / BEAT_LANES_DEF;
    localparam int BEAT_IDX_W = $clog2(NUM_BEATS);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    // Index width that stays legal (>= 1 bit) for degenerate counts of 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pe_result_collector_if.sv
// Beat-level valid/ready write channel from the result collector to the on-chip buffer.
interface pe_result_collector_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 54,
    parameter int BEAT_LANES = 16
);
    logic                             wr_valid;
    logic                             wr_ready;
    logic [ADDR_WIDTH-1:0]            wr_addr;
    logic [DATA_WIDTH*BEAT_LANES-1:0] wr_data;

    modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/pe_issue_delay.sv
// Mirrors the fixed PE array latency: a {valid, addr} shift register plus a
// running count of occupied stages, used for issue credit accounting.
module pe_issue_delay
    import pe_pkg::*;
#(
    parameter int PE_LATENCY = PE_LATENCY_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int IW         = idx_w(PE_LATENCY + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [IW-1:0]         inflight
);
    logic [PE_LATENCY-1:0]                 vld_pipe;
    logic [PE_LATENCY-1:0][ADDR_WIDTH-1:0] addr_pipe;

    assign out_valid = vld_pipe[PE_LATENCY-1];
    assign out_addr  = addr_pipe[PE_LATENCY-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
            inflight  <= '0;
        end else begin
            vld_pipe[0]  <= load;
            addr_pipe[0] <= load_addr;
            for (int i = 1; i < PE_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
            inflight <= inflight + IW'(load) - IW'(out_valid);
        end
    end
endmodule

// File: rtl/pe_result_collector.sv
// Captures PE array result vectors into a two-slot ping-pong store and drains
// each as BEAT_LANES-wide write beats; issue credits guarantee no result is lost.
module pe_result_collector
    import pe_pkg::*;
#(
    parameter int DP         = DP_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BEAT_LANES = BEAT_LANES_DEF,
    parameter int PE_LATENCY = PE_LATENCY_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [ADDR_WIDTH-1:0]      issue_addr,
    input  logic [DATA_WIDTH*DP-1:0]   pe_output_data,
    pe_result_collector_if.master      wr,
    output logic                       busy,
    output logic                       err_protocol,
    input  logic                       clear_err
);
    localparam int NB     = DP / BEAT_LANES;
    localparam int BW     = idx_w(NB);
    localparam int IW     = idx_w(PE_LATENCY + 1);
    localparam int OW     = IW + 1;
    localparam int BEAT_W = DATA_WIDTH * BEAT_LANES;

    if ((DP % BEAT_LANES) != 0 || PE_LATENCY < 1) begin : g_cfg_err
        $error("pe_result_collector: DP must be a multiple of BEAT_LANES and PE_LATENCY >= 1");
    end

    drain_state_e                          state;
    logic [1:0]                            count, count_nxt;
    logic [IW-1:0]                         inflight;
    logic [OW-1:0]                         occ;
    logic                                  wr_ptr, rd_ptr;
    logic [BW-1:0]                         beat;
    logic [1:0][DATA_WIDTH*DP-1:0]         slot_data;
    logic [1:0][ADDR_WIDTH-1:0]            slot_addr;
    logic                                  accept, cap_valid, hs, last;
    logic [ADDR_WIDTH-1:0]                 cap_addr;

    // Credits depend only on registered occupancy so issue_ready has no
    // combinational path from the write sink or the issuer.
    assign occ         = OW'(count) + OW'(inflight);
    assign issue_ready = (occ < OW'(2));
    assign accept      = issue_valid & issue_ready;
    assign busy        = (count != 2'd0) | (inflight != '0);

    pe_issue_delay #(
        .PE_LATENCY (PE_LATENCY),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IW         (IW)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_addr (issue_addr),
        .out_valid (cap_valid),
        .out_addr  (cap_addr),
        .inflight  (inflight)
    );

    assign wr.wr_valid = (state == DRAIN);
    assign wr.wr_data  = wr.wr_valid ? slot_data[rd_ptr][int'(beat)*BEAT_W +: BEAT_W] : '0;
    assign wr.wr_addr  = wr.wr_valid ? slot_addr[rd_ptr] + ADDR_WIDTH'(beat) : '0;

    assign hs        = wr.wr_valid & wr.wr_ready;
    assign last      = hs & (beat == BW'(NB - 1));
    assign count_nxt = count + 2'(cap_valid) - 2'(last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            beat         <= '0;
            err_protocol <= 1'b0;
        end else begin
            count <= count_nxt;
            if (cap_valid) wr_ptr <= ~wr_ptr;

            if (clear_err)                        err_protocol <= 1'b0;
            else if (issue_valid && !issue_ready) err_protocol <= 1'b1;

            // Entering DRAIN on the capture itself gives a one-cycle
            // capture-to-valid latency.
            if (state == IDLE) begin
                if (count != 2'd0 || cap_valid) state <= DRAIN;
            end else if (hs) begin
                if (last) begin
                    beat   <= '0;
                    rd_ptr <= ~rd_ptr;
                    if (count_nxt == 2'd0) state <= IDLE;
                end else begin
                    beat <= beat + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_valid) begin
            slot_data[wr_ptr] <= pe_output_data;
            slot_addr[wr_ptr] <= cap_addr;
        end
    end
endmodule

// File: tb/tb_pe_result_collector.sv
// Directed bench for pe_result_collector: beat ordering, credits, stalls,
// protocol error, address wrap and mid-drain reset.
module tb_pe_result_collector;
    localparam int DP = 256;
    localparam int DW = 54;
    localparam int BL = 16;
    localparam int PL = 4;
    localparam int AW = 16;
    localparam int BW = DW * BL;

    logic            clk;
    logic            rst;
    logic            issue_valid;
    logic            issue_ready;
    logic [AW-1:0]   issue_addr;
    logic [DW*DP-1:0] pe_data;
    logic            busy;
    logic            err_protocol;
    logic            clear_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [AW-1:0] log_addr[$];
    logic [BW-1:0] log_data[$];
    int            log_cyc[$];

    pe_result_collector_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEAT_LANES(BL)) wif ();

    pe_result_collector #(
        .DP(DP), .DATA_WIDTH(DW), .BEAT_LANES(BL), .PE_LATENCY(PL), .ADDR_WIDTH(AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_addr     (issue_addr),
        .pe_output_data (pe_data),
        .wr             (wif),
        .busy           (busy),
        .err_protocol   (err_protocol),
        .clear_err      (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat log: every accepted write beat with the cycle it was accepted in.
    always @(posedge clk) begin
        if (rst && wif.wr_valid && wif.wr_ready) begin
            log_addr.push_back(wif.wr_addr);
            log_data.push_back(wif.wr_data);
            log_cyc.push_back(cyc);
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic log_clear();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic set_pattern(input int base);
        for (int i = 0; i < DP; i++) pe_data[i*DW +: DW] = DW'(base + i);
    endtask

    function automatic logic [BW-1:0] exp_beat(input int base, input int k);
        logic [BW-1:0] r;
        for (int j = 0; j < BL; j++) r[j*DW +: DW] = DW'(base + k*BL + j);
        return r;
    endfunction

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < max; t++) begin
            tick();
            if (!busy && !wif.wr_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %b expected 1", issue_ready); end
        n_checks++; if (wif.wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b expected 0", wif.wr_valid); end
        n_checks++; if (wif.wr_addr !== 16'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %h expected 0", wif.wr_addr); end
        n_checks++; if (wif.wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 0", wif.wr_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (err_protocol !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_protocol); end
    endtask

    task automatic test_single();
        int c0;
        bit ok;
        log_clear();
        set_pattern(0);
        wif.wr_ready = 1'b1;
        c0 = cyc;
        issue_valid = 1'b1; issue_addr = 16'h0100;
        tick();
        issue_valid = 1'b0;
        repeat (3) tick();
        n_checks++; if (wif.wr_valid !== 1'b0) begin n_fail++; $display("FAIL single_pre_valid: got %b expected 0", wif.wr_valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_inflight: got %b expected 1", busy); end
        tick();
        n_checks++; if (wif.wr_valid !== 1'b1) begin n_fail++; $display("FAIL single_first_valid: got %b expected 1", wif.wr_valid); end
        wait_idle(100, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_idle_timeout: got %b expected 1", ok); end
        n_checks++; if (log_addr.size() != 16) begin n_fail++; $display("FAIL single_beat_count: got %0d expected 16", log_addr.size()); end
        for (int k = 0; k < 16 && k < log_addr.size(); k++) begin
            n_checks++; if (log_addr[k] !== AW'(16'h0100 + k)) begin n_fail++; $display("FAIL single_addr[%0d]: got %h expected %h", k, log_addr[k], AW'(16'h0100 + k)); end
            n_checks++; if (log_data[k] !== exp_beat(0, k)) begin n_fail++; $display("FAIL single_data[%0d]: got %h expected %h", k, log_data[k], exp_beat(0, k)); end
            n_checks++; if (log_cyc[k] != c0 + 5 + k) begin n_fail++; $display("FAIL single_cycle[%0d]: got %0d expected %0d", k, log_cyc[k], c0 + 5 + k); end
        end
    endtask

    task automatic test_back_to_back();
        int c0, rc;
        bit ok;
        logic [AW-1:0] bases [3];
        bases[0] = 16'h0400; bases[1] = 16'h0500; bases[2] = 16'h0600;
        log_clear();
        set_pattern(32'h1000);
        wif.wr_ready = 1'b1;
        c0 = cyc;
        issue_valid = 1'b1; issue_addr = bases[0];
        tick();
        issue_addr = bases[1];
        tick();
        issue_valid = 1'b0;
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_credit_full: got %b expected 0", issue_ready); end
        rc = -1;
        for (int t = 0; t < 100; t++) begin
            if (issue_ready) begin rc = cyc; break; end
            tick();
        end
        n_checks++; if (rc != c0 + 21) begin n_fail++; $display("FAIL b2b_credit_return: got cycle %0d expected %0d", rc, c0 + 21); end
        issue_valid = 1'b1; issue_addr = bases[2];
        tick();
        issue_valid = 1'b0;
        wait_idle(200, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_timeout: got %b expected 1", ok); end
        n_checks++; if (log_addr.size() != 48) begin n_fail++; $display("FAIL b2b_beat_count: got %0d expected 48", log_addr.size()); end
        for (int k = 0; k < 48 && k < log_addr.size(); k++) begin
            n_checks++; if (log_addr[k] !== AW'(bases[k/16] + k%16)) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %h expected %h", k, log_addr[k], AW'(bases[k/16] + k%16)); end
            n_checks++; if (log_data[k] !== exp_beat(32'h1000, k%16)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, log_data[k], exp_beat(32'h1000, k%16)); end
            n_checks++; if (log_cyc[k] != c0 + 5 + k) begin n_fail++; $display("FAIL b2b_no_bubble[%0d]: got cycle %0d expected %0d", k, log_cyc[k], c0 + 5 + k); end
        end
        n_checks++; if (err_protocol !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b expected 0", err_protocol); end
    endtask

    task automatic test_stall();
        int c0;
        bit ok, stalled;
        logic [AW-1:0] h_addr;
        logic [BW-1:0] h_data;
        log_clear();
        set_pattern(0);
        stalled = 1'b0;
        c0 = cyc;
        wif.wr_ready = 1'b1;
        issue_valid = 1'b1; issue_addr = 16'h0100;
        ok = 1'b0;
        for (int t = 0; t < 120; t++) begin
            if (stalled) begin
                n_checks++; if (wif.wr_addr !== h_addr) begin n_fail++; $display("FAIL stall_hold_addr: got %h expected %h", wif.wr_addr, h_addr); end
                n_checks++; if (wif.wr_data !== h_data) begin n_fail++; $display("FAIL stall_hold_data: got %h expected %h", wif.wr_data, h_data); end
            end
            wif.wr_ready = ((cyc - c0) % 4 == 0) || ((cyc - c0) % 4 == 3);
            stalled = wif.wr_valid && !wif.wr_ready;
            h_addr = wif.wr_addr;
            h_data = wif.wr_data;
            tick();
            issue_valid = 1'b0;
            if (t > 4 && !busy && !wif.wr_valid) begin ok = 1'b1; break; end
        end
        wif.wr_ready = 1'b1;
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_idle_timeout: got %b expected 1", ok); end
        n_checks++; if (log_addr.size() != 16) begin n_fail++; $display("FAIL stall_beat_count: got %0d expected 16", log_addr.size()); end
        for (int k = 0; k < 16 && k < log_addr.size(); k++) begin
            n_checks++; if (log_addr[k] !== AW'(16'h0100 + k)) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h expected %h", k, log_addr[k], AW'(16'h0100 + k)); end
            n_checks++; if (log_data[k] !== exp_beat(0, k)) begin n_fail++; $display("FAIL stall_data[%0d]: got %h expected %h", k, log_data[k], exp_beat(0, k)); end
        end
    endtask

    task automatic test_protocol_err();
        bit ok;
        log_clear();
        set_pattern(32'h2000);
        wif.wr_ready = 1'b1;
        issue_valid = 1'b1; issue_addr = 16'h0200;
        tick();
        issue_addr = 16'h0300;
        tick();
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL err_ready_low: got %b expected 0", issue_ready); end
        issue_addr = 16'h0400;
        tick();
        n_checks++; if (err_protocol !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err_protocol); end
        clear_err = 1'b1;
        tick();
        n_checks++; if (err_protocol !== 1'b0) begin n_fail++; $display("FAIL err_clear_priority: got %b expected 0", err_protocol); end
        clear_err = 1'b0;
        tick();
        n_checks++; if (err_protocol !== 1'b1) begin n_fail++; $display("FAIL err_set_again: got %b expected 1", err_protocol); end
        issue_valid = 1'b0;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        n_checks++; if (err_protocol !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", err_protocol); end
        wait_idle(200, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL err_idle_timeout: got %b expected 1", ok); end
        n_checks++; if (log_addr.size() != 32) begin n_fail++; $display("FAIL err_beat_count: got %0d expected 32", log_addr.size()); end
        for (int k = 0; k < 32 && k < log_addr.size(); k++) begin
            n_checks++; if (log_addr[k] !== AW'((k < 16 ? 16'h0200 : 16'h0300) + k%16)) begin n_fail++; $display("FAIL err_addr[%0d]: got %h expected %h", k, log_addr[k], AW'((k < 16 ? 16'h0200 : 16'h0300) + k%16)); end
        end
    endtask

    task automatic test_addr_wrap();
        bit ok;
        log_clear();
        set_pattern(32'h3000);
        wif.wr_ready = 1'b1;
        issue_valid = 1'b1; issue_addr = 16'hFFF8;
        tick();
        issue_valid = 1'b0;
        wait_idle(100, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wrap_idle_timeout: got %b expected 1", ok); end
        n_checks++; if (log_addr.size() != 16) begin n_fail++; $display("FAIL wrap_beat_count: got %0d expected 16", log_addr.size()); end
        for (int k = 0; k < 16 && k < log_addr.size(); k++) begin
            n_checks++; if (log_addr[k] !== AW'(32'hFFF8 + k)) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h expected %h", k, log_addr[k], AW'(32'hFFF8 + k)); end
            n_checks++; if (log_data[k] !== exp_beat(32'h3000, k)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", k, log_data[k], exp_beat(32'h3000, k)); end
        end
    endtask

    task automatic test_reset_mid_drain();
        int nvalid;
        log_clear();
        set_pattern(0);
        wif.wr_ready = 1'b1;
        issue_valid = 1'b1; issue_addr = 16'h0700;
        tick();
        issue_addr = 16'h0800;
        tick();
        issue_valid = 1'b0;
        repeat (10) tick();
        n_checks++; if (wif.wr_addr !== 16'h0707) begin n_fail++; $display("FAIL rstmid_at_beat7: got %h expected 0707", wif.wr_addr); end
        rst = 1'b0;
        #1;
        test_reset();
        tick();
        rst = 1'b1;
        nvalid = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (wif.wr_valid) nvalid++;
        end
        n_checks++; if (nvalid != 0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d expected 0", nvalid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_checks++; if (log_addr.size() != 7) begin n_fail++; $display("FAIL rstmid_beats_before: got %0d expected 7", log_addr.size()); end
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0;
        issue_addr = '0;
        pe_data = '0;
        clear_err = 1'b0;
        wif.wr_ready = 1'b0;
        #2 rst = 1'b0;
        tick();
        tick();
        test_reset();
        rst = 1'b1;
        tick();
        test_single();
        test_back_to_back();
        test_stall();
        test_protocol_err();
        test_addr_wrap();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_result_collector.md
Name: pe_result_collector

Overview:
- Sits at the output side of the PE array and closes its datapath.
- Tracks vectors issued into the fixed-latency PE array and captures each DP-lane result vector when it emerges.
- Buffers up to two results in a ping-pong store and serialises each one as BEAT_LANES-lane beats onto a valid/ready write port toward the on-chip buffer.
- Grants issue credits upstream so results are never dropped.

Parameters:
- DP, 256: lanes per result vector.
- DATA_WIDTH, 54: bits per lane (modular residue).
- BEAT_LANES, 16: lanes per write beat; DP % BEAT_LANES must be 0.
- PE_LATENCY, 4: cycles from issue to a valid pe_output_data; must be >= 1.
- ADDR_WIDTH, 16: write address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  vector enters the PE array this cycle.
- issue_ready  out  1  credit available; upstream issues only when high.
- issue_addr  in  ADDR_WIDTH  base write address for this vector.
- pe_output_data  in  DATA_WIDTH*DP  PE array result bus, lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- wr_valid  out  1  write beat valid.
- wr_ready  in  1  sink accepts beat.
- wr_addr  out  ADDR_WIDTH  beat address.
- wr_data  out  DATA_WIDTH*BEAT_LANES  beat payload.
- busy  out  1  any vector in flight, buffered or draining.
- err_protocol  out  1  sticky: issue_valid seen while issue_ready was low.
- clear_err  in  1  synchronous clear of err_protocol.

Behaviour:
- Reset (rst=0, asynchronous): all flags and counters clear.
  - issue_ready=1; wr_valid=0, wr_addr=0, wr_data=0, busy=0, err_protocol=0.
  - Delay line is emptied; in-flight results are discarded; drain FSM returns to IDLE.
- Delay line: PE_LATENCY-stage shift register of {valid, addr}.
  - Stage 0 loads on an accepted issue (issue_valid & issue_ready).
  - At stage-out valid, pe_output_data and addr are captured into slot[wr_ptr]; wr_ptr toggles.
- Credits:
  - issue_ready = (count + inflight) < 2, computed only from registered count and inflight. No combinational path from wr_ready or issue_valid.
  - inflight = number of valid delay-line stages.
  - count = number of full slots, 0..2.
- Protocol error: issue_valid while issue_ready=0 sets err_protocol.
  - That issue is ignored and not loaded into the delay line.
  - clear_err has priority over a same-cycle set.
- Drain FSM, states IDLE and DRAIN; beat index 0..DP/BEAT_LANES-1.
  - IDLE -> DRAIN when count > 0. wr_valid rises the cycle after the capture, so capture-to-wr_valid latency is 1 cycle.
  - In DRAIN: wr_valid=1; wr_data = slot[rd_ptr] lanes [beat*BEAT_LANES +: BEAT_LANES]; wr_addr = slot addr + beat, modulo 2^ADDR_WIDTH.
  - wr_data and wr_addr hold stable while wr_valid & !wr_ready.
  - On each handshake, beat increments.
  - On the last-beat handshake: the slot is freed, rd_ptr toggles, beat returns to 0. Stay in DRAIN if another slot is full (including one captured in the same cycle); otherwise go to IDLE.
  - Back-to-back vectors drain with no bubble.
- Simultaneous capture and last-beat free: count is unchanged.
- A freed credit appears on issue_ready the cycle after the freeing handshake.
- busy = (count != 0) | (inflight != 0).
- Widths: wr_addr addition wraps silently; no saturation.

Decomposition:
- Shared package pe_pkg: lane slice width, NUM_BEATS = DP/BEAT_LANES, beat-index width $clog2(NUM_BEATS), and the drain-state enum {IDLE, DRAIN}. The PE array and its operand feeder share these.
- One natural sub-module: pe_issue_delay, the PE_LATENCY-deep {valid, addr} shift register with an in-flight counter.

Test Plan:
- Single vector: issue at cycle 0 with issue_addr=0x0100, lane i = i; wr_ready=1.
  -> Capture at cycle 4; wr_valid cycles 5..20; 16 beats at addr 0x0100..0x010F; beat k carries lanes 16k..16k+15.
- Three consecutive issue attempts, wr_ready=1.
  -> issue_ready drops after two accepted issues; the third is accepted only after the first vector's last beat; 48 beats with no gap between vectors; err_protocol stays 0.
- wr_ready toggling 1,0,0,1 repeating.
  -> wr_data and wr_addr are held during stalls; no beat is lost or duplicated; the beat sequence is identical to the single-vector case.
- Issue while issue_ready=0.
  -> err_protocol=1 the next cycle; no extra beats appear. Then clear_err=1 -> err_protocol=0.
- Issue with issue_addr=0xFFF8.
  -> Beats at 0xFFF8..0xFFFF, then 0x0000..0x0007.
- rst asserted mid-drain at beat 7 with a second vector in flight.
  -> Outputs go to reset values immediately; after release there is no wr_valid and busy=0.
